// File: rtl/gray_counter_nbit.sv
// N-bit up/down counter with registered binary and Gray views, parallel load in either code.
// Define GRAY_CNT_SATURATE_EN to saturate at the ends instead of wrapping.
`default_nettype none

module gray_counter_nbit #(
    parameter int          WIDTH   = 4,
    parameter logic [31:0] RST_VAL = 32'd0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             dir_in,
    input  logic             load_in,
    input  logic             load_gray_in,
    input  logic [WIDTH-1:0] load_val_in,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap_out,
    output logic             zero_out
);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("gray_counter_nbit: WIDTH must be in 2..32");
        end
        if (WIDTH < 32 && (RST_VAL >> WIDTH) != 32'd0) begin : g_bad_rst
            $error("gray_counter_nbit: RST_VAL does not fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q, wrap_d;
    logic             zero_q;
    logic             at_end;

    // at_end: the next step in the current direction would cross the modulo boundary
    assign at_end = dir_in ? (bin_q == MAX_VAL) : (bin_q == '0);

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load_in) begin
            bin_d = load_gray_in ? gray_to_bin(load_val_in) : load_val_in;
        end else if (en_in) begin
            wrap_d = at_end;
`ifdef GRAY_CNT_SATURATE_EN
            if (!at_end) begin
                bin_d = dir_in ? bin_q + 1'b1 : bin_q - 1'b1;
            end
`else
            bin_d = dir_in ? bin_q + 1'b1 : bin_q - 1'b1;
`endif
        end
    end

    // All outputs derive from bin_d so they stay mutually consistent.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
            zero_q <= (RST_BIN == '0);
        end else begin
            bin_q  <= bin_d;
            gray_q <= bin_d ^ (bin_d >> 1);
            wrap_q <= wrap_d;
            zero_q <= (bin_d == '0);
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap_out = wrap_q;
    assign zero_out = zero_q;

endmodule

`default_nettype wire
